axis_rr_arb: RTL and testbench
==============================

AXIS_RR_ARB -- requirements
Module: axis_rr_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of AXI-Stream slave inputs, 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: tdata width in bits per port.
REQ-003 SHALL have port aclk, input, 1: single clock; every register updates on its rising edge.
REQ-004 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tvalid, input, NUM_PORTS: per-port valid; bit i belongs to port i.
REQ-006 SHALL have port s_axis_tready, output, NUM_PORTS: per-port ready.
REQ-007 SHALL have port s_axis_tdata, input, NUM_PORTS*DATA_W: flattened data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port s_axis_tlast, input, NUM_PORTS: per-port end-of-packet.
REQ-009 SHALL have port m_axis_tvalid, output, 1: registered output valid.
REQ-010 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-011 SHALL have port m_axis_tdata, output, DATA_W: registered output data.
REQ-012 SHALL have port m_axis_tlast, output, 1: registered output last.

Function
REQ-013 SHALL run an FSM with two states:
- IDLE: no grant held.
- BUSY: one port granted until its tlast beat is accepted.
REQ-014 In IDLE with any s_axis_tvalid bit set, SHALL select a port round-robin, register the grant and enter BUSY on the next edge.
- Selection is the first requesting port starting at index ptr and wrapping modulo NUM_PORTS.
- Arbitration latency is 1 cycle.
REQ-015 SHALL drive s_axis_tready[i] = (state==BUSY) && (grant==i) && (!m_axis_tvalid || m_axis_tready); all non-granted ready bits SHALL be 0.
REQ-016 A beat is accepted on port g when s_axis_tvalid[g] && s_axis_tready[g]; its tdata and tlast SHALL appear on m_axis_* with m_axis_tvalid=1 on the next cycle (1-cycle latency).
REQ-017 When the output holds a beat and m_axis_tready=0, m_axis_tvalid/tdata/tlast SHALL stay stable.
REQ-018 When the output holds a beat, m_axis_tready=1 and no new beat is accepted, m_axis_tvalid SHALL go 0 on the next cycle.
REQ-019 Sustained throughput within a packet SHALL be 1 beat/cycle while m_axis_tready=1.
REQ-020 When a beat with tlast=1 is accepted, the FSM SHALL return to IDLE and set ptr=(g+1) mod NUM_PORTS.
- This gives one idle cycle between packets.
REQ-021 The grant SHALL NOT change mid-packet.
- If s_axis_tvalid[g] drops mid-packet, the FSM SHALL hold BUSY on g.
- Other requesters SHALL wait.
REQ-022 A single requester SHALL be re-granted repeatedly after one idle cycle per packet.
REQ-023 A one-beat packet (tlast on the first beat) SHALL be handled: BUSY for exactly one accept cycle.

Reset
REQ-024 When areset=1 at a rising edge, the following SHALL be set:
- state=IDLE, ptr=0, grant=0;
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
REQ-025 During reset, all s_axis_tready bits SHALL be 0.
REQ-026 Reset asserted mid-packet SHALL discard the in-flight beat and the partial packet with no recovery.

Configuration
REQ-027 With macro AXIS_ARB_TID_EN defined, SHALL add an output port m_axis_tid, width $clog2(NUM_PORTS).
- It is registered alongside m_axis_tdata and carries the source port index of each beat.
- Reset value is 0.
REQ-028 Without AXIS_ARB_TID_EN, port m_axis_tid and its register SHALL NOT exist, and behaviour SHALL be otherwise identical.

Structure
REQ-029 Package axis_arb_pkg SHALL hold the FSM state typedef (IDLE, BUSY) and the default NUM_PORTS/DATA_W constants.
REQ-030 Round-robin selection SHALL be a sub-module axis_rr_pick:
- Inputs: request vector and ptr.
- Outputs: one index plus a found flag.
- Purely combinational.

Verification
REQ-031 Reset, then port 0 sends a 3-beat packet 0x11,0x22,0x33 (tlast on 0x33) with m_axis_tready=1.
- Required: m_axis_tdata 0x11,0x22,0x33 on consecutive cycles, m_axis_tlast only with 0x33, then ptr=1.
REQ-032 Ports 0..3 request simultaneously, each with a 1-beat packet, after reset.
- Required: grant order 0,1,2,3, each beat 2 cycles apart.
REQ-033 Port 2 is mid-packet and port 1 requests.
- Required: port 1 sees s_axis_tready[1]=0 until port 2's tlast beat is accepted, then port 1 is granted next.
REQ-034 m_axis_tready=0 for 4 cycles while holding beat 0xA5.
- Required: m_axis_tdata=0xA5 and m_axis_tvalid=1 stable, and s_axis_tready[g]=0 throughout.
REQ-035 areset=1 for 1 cycle mid-packet.
- Required: m_axis_tvalid=0 next cycle, all ready bits 0, and a fresh grant starting from port 0.
REQ-036 With AXIS_ARB_TID_EN defined, rerun REQ-032.
- Required: m_axis_tid=0,1,2,3 matches each beat's source.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter: FSM state
// type, default sizing constants and a small modular-index helper.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 8;

  // Adds two indices that are both below n and wraps the sum back into 0..n-1.
  function automatic int wrapAdd(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after i_ptr, wrapping around the request vector, plus a found flag.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDXW      = $clog2(DEF_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDXW-1:0]      i_ptr,
  output logic [IDXW-1:0]      o_idx,
  output logic                 o_found
);

  logic [IDXW-1:0] w_pos;

  // Scan from the farthest offset back to the pointer so the nearest request wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_pos = IDXW'(wrapAdd(int'(i_ptr), k, NUM_PORTS));
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arb.sv
// AXI-Stream packet arbiter: NUM_PORTS slave streams share one registered
// master stream, with round-robin grants held for a whole packet.
// Optional feature: define AXIS_ARB_TID_EN to add m_axis_tid carrying the
// source port index of every output beat.
module axis_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tlast
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [$clog2(NUM_PORTS)-1:0]  m_axis_tid
`endif
);

  localparam int IDXW = $clog2(NUM_PORTS);

  arb_state_t          r_state;
  logic [IDXW-1:0]     r_ptr;
  logic [IDXW-1:0]     r_grant;
  logic                r_mValid;
  logic [DATA_W-1:0]   r_mData;
  logic                r_mLast;

  logic [IDXW-1:0]     w_pickIdx;
  logic                w_pickFound;
  logic                w_outFree;
  logic                w_accept;
  logic [IDXW-1:0]     w_nextPtr;

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDXW      (IDXW)
  ) u_pick (
    .i_req   (s_axis_tvalid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pickIdx),
    .o_found (w_pickFound)
  );

  // The output register can take a beat when it is empty or being drained.
  assign w_outFree = !r_mValid || m_axis_tready;

  // Only the granted port sees ready, and never while reset is asserted.
  always_comb begin
    s_axis_tready = '0;
    if (!areset && (r_state == BUSY) && w_outFree) begin
      s_axis_tready[r_grant] = 1'b1;
    end
  end

  assign w_accept  = s_axis_tvalid[r_grant] && s_axis_tready[r_grant];
  assign w_nextPtr = (r_grant == IDXW'(NUM_PORTS - 1)) ? '0 : (r_grant + IDXW'(1));

  // Grant FSM: pick in IDLE, hold the grant until the tlast beat is accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickFound) begin
            r_grant <= w_pickIdx;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && s_axis_tlast[r_grant]) begin
            r_state <= IDLE;
            r_ptr   <= w_nextPtr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: load on accept, hold under backpressure, empty when drained.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
      r_mLast  <= 1'b0;
    end else if (w_accept) begin
      r_mValid <= 1'b1;
      r_mData  <= s_axis_tdata[r_grant*DATA_W +: DATA_W];
      r_mLast  <= s_axis_tlast[r_grant];
    end else if (m_axis_tready) begin
      r_mValid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_TID_EN
  logic [IDXW-1:0] r_mTid;

  // Source index travels with the data it was accepted alongside.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mTid <= '0;
    end else if (w_accept) begin
      r_mTid <= r_grant;
    end
  end

  assign m_axis_tid = r_mTid;
`else
  // Source index is not tracked in this build.
`endif

  assign m_axis_tvalid = r_mValid;
  assign m_axis_tdata  = r_mData;
  assign m_axis_tlast  = r_mLast;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Self-checking bench for axis_rr_arb (4 ports, 8-bit data). Directed
// scenarios plus a randomized run against a packet-level reference model.
// Define AXIS_ARB_TID_EN to also check m_axis_tid.
module tb_axis_rr_arb;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [NP-1:0]     sValid = '0;
  logic [NP-1:0]     sReady;
  logic [NP*DW-1:0]  sData = '0;
  logic [NP-1:0]     sLast = '0;
  logic              mValid;
  logic              mReady = 1'b1;
  logic [DW-1:0]     mData;
  logic              mLast;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0]     mTid;
`endif

  int nChecks = 0;
  int nPass   = 0;

  logic [8:0] pktQ [NP][$];

  axis_rr_arb #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (sValid),
    .s_axis_tready (sReady),
    .s_axis_tdata  (sData),
    .s_axis_tlast  (sLast),
    .m_axis_tvalid (mValid),
    .m_axis_tready (mReady),
    .m_axis_tdata  (mData),
    .m_axis_tlast  (mLast)
`ifdef AXIS_ARB_TID_EN
    ,
    .m_axis_tid    (mTid)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic setPort(input int p, input logic [7:0] d, input logic l);
    sData[p*DW +: DW] = d;
    sLast[p] = l;
  endtask

  task automatic doReset();
    areset = 1'b1;
    sValid = '0;
    sLast  = '0;
    sData  = '0;
    mReady = 1'b1;
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    sValid = '1;
    mReady = 1'b1;
    step();
    nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b expected 0", mValid); else nPass++;
    nChecks++; if (mData !== 8'h00) $display("[TB] FAIL reset_tdata: got %h expected 00", mData); else nPass++;
    nChecks++; if (mLast !== 1'b0) $display("[TB] FAIL reset_tlast: got %b expected 0", mLast); else nPass++;
    step();
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL reset_tready: got %b expected 0000", sReady); else nPass++;
`ifdef AXIS_ARB_TID_EN
    nChecks++; if (mTid !== 2'd0) $display("[TB] FAIL reset_tid: got %0d expected 0", mTid); else nPass++;
`else
`endif
    areset = 1'b0;
    sValid = '0;
    step();
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL idle_tready: got %b expected 0000", sReady); else nPass++;
  endtask

  task automatic test_single_packet();
    doReset();
    sValid = 4'b0001;
    setPort(0, 8'h11, 1'b0);
    step();
    nChecks++; if (sReady !== 4'b0001) $display("[TB] FAIL pkt_grant: got %b expected 0001", sReady); else nPass++;
    nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL pkt_latency: tvalid %b expected 0", mValid); else nPass++;
    step();
    nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b0, 8'h11}) $display("[TB] FAIL pkt_beat0: got v%b l%b %h expected v1 l0 11", mValid, mLast, mData); else nPass++;
    setPort(0, 8'h22, 1'b0);
    step();
    nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b0, 8'h22}) $display("[TB] FAIL pkt_beat1: got v%b l%b %h expected v1 l0 22", mValid, mLast, mData); else nPass++;
    setPort(0, 8'h33, 1'b1);
    step();
    nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b1, 8'h33}) $display("[TB] FAIL pkt_beat2: got v%b l%b %h expected v1 l1 33", mValid, mLast, mData); else nPass++;
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL pkt_idle_gap: got %b expected 0000", sReady); else nPass++;
    sValid = 4'b0011;
    setPort(0, 8'h40, 1'b1);
    setPort(1, 8'h41, 1'b1);
    step();
    nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL pkt_drain: tvalid %b expected 0", mValid); else nPass++;
    nChecks++; if (sReady !== 4'b0010) $display("[TB] FAIL pkt_ptr_next: got %b expected 0010", sReady); else nPass++;
    step();
    nChecks++; if ({mValid, mData} !== {1'b1, 8'h41}) $display("[TB] FAIL pkt_port1_beat: got v%b %h expected v1 41", mValid, mData); else nPass++;
    sValid = 4'b0001;
    step();
    nChecks++; if (sReady !== 4'b0001) $display("[TB] FAIL pkt_wrap_grant: got %b expected 0001", sReady); else nPass++;
    step();
    nChecks++; if ({mValid, mData} !== {1'b1, 8'h40}) $display("[TB] FAIL pkt_port0_beat: got v%b %h expected v1 40", mValid, mData); else nPass++;
    sValid = '0;
    step();
  endtask

  task automatic test_simultaneous();
    doReset();
    sValid = 4'b1111;
    for (int p = 0; p < NP; p++) setPort(p, 8'hA0 + 8'(p), 1'b1);
    for (int k = 0; k < NP; k++) begin
      step();
      nChecks++; if (sReady !== 4'(1 << k)) $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, sReady, 4'(1 << k)); else nPass++;
      nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL rr_gap%0d: tvalid %b expected 0", k, mValid); else nPass++;
      step();
      nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b1, 8'hA0 + 8'(k)}) $display("[TB] FAIL rr_beat%0d: got v%b l%b %h expected v1 l1 %h", k, mValid, mLast, mData, 8'hA0 + 8'(k)); else nPass++;
`ifdef AXIS_ARB_TID_EN
      nChecks++; if (mTid !== IW'(k)) $display("[TB] FAIL rr_tid%0d: got %0d expected %0d", k, mTid, k); else nPass++;
`else
`endif
      sValid[k] = 1'b0;
    end
    step();
  endtask

  task automatic test_mid_packet();
    doReset();
    sValid = 4'b0100;
    setPort(2, 8'h50, 1'b0);
    step();
    nChecks++; if (sReady !== 4'b0100) $display("[TB] FAIL mid_grant2: got %b expected 0100", sReady); else nPass++;
    step();
    nChecks++; if (mData !== 8'h50) $display("[TB] FAIL mid_beat0: got %h expected 50", mData); else nPass++;
    sValid = 4'b0010;
    setPort(1, 8'h60, 1'b1);
    step();
    nChecks++; if (sReady !== 4'b0100) $display("[TB] FAIL mid_hold: got %b expected 0100", sReady); else nPass++;
    nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL mid_drain: tvalid %b expected 0", mValid); else nPass++;
    sValid = 4'b0110;
    setPort(2, 8'h51, 1'b0);
    step();
    nChecks++; if ({mValid, mData} !== {1'b1, 8'h51}) $display("[TB] FAIL mid_beat1: got v%b %h expected v1 51", mValid, mData); else nPass++;
    nChecks++; if (sReady[1] !== 1'b0) $display("[TB] FAIL mid_port1_wait: got %b expected 0", sReady[1]); else nPass++;
    setPort(2, 8'h52, 1'b1);
    step();
    nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b1, 8'h52}) $display("[TB] FAIL mid_beat2: got v%b l%b %h expected v1 l1 52", mValid, mLast, mData); else nPass++;
    sValid = 4'b0010;
    step();
    nChecks++; if (sReady !== 4'b0010) $display("[TB] FAIL mid_port1_grant: got %b expected 0010", sReady); else nPass++;
    step();
    nChecks++; if ({mValid, mData} !== {1'b1, 8'h60}) $display("[TB] FAIL mid_port1_beat: got v%b %h expected v1 60", mValid, mData); else nPass++;
    sValid = '0;
    step();
  endtask

  task automatic test_backpressure();
    doReset();
    sValid = 4'b0001;
    setPort(0, 8'hA5, 1'b0);
    step();
    step();
    mReady = 1'b0;
    setPort(0, 8'hB6, 1'b1);
    #1;
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL bp_ready_drop: got %b expected 0000", sReady); else nPass++;
    for (int c = 0; c < 4; c++) begin
      step();
      nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b0, 8'hA5}) $display("[TB] FAIL bp_hold%0d: got v%b l%b %h expected v1 l0 a5", c, mValid, mLast, mData); else nPass++;
      nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL bp_ready%0d: got %b expected 0000", c, sReady); else nPass++;
    end
    mReady = 1'b1;
    #1;
    nChecks++; if (sReady !== 4'b0001) $display("[TB] FAIL bp_release: got %b expected 0001", sReady); else nPass++;
    step();
    nChecks++; if ({mValid, mLast, mData} !== {1'b1, 1'b1, 8'hB6}) $display("[TB] FAIL bp_next: got v%b l%b %h expected v1 l1 b6", mValid, mLast, mData); else nPass++;
    sValid = '0;
    step();
    nChecks++; if (mValid !== 1'b0) $display("[TB] FAIL bp_empty: tvalid %b expected 0", mValid); else nPass++;
  endtask

  task automatic test_reset_mid_packet();
    doReset();
    sValid = 4'b0100;
    setPort(2, 8'h70, 1'b0);
    step();
    step();
    setPort(2, 8'h71, 1'b0);
    areset = 1'b1;
    #1;
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL rst_mid_ready: got %b expected 0000", sReady); else nPass++;
    step();
    areset = 1'b0;
    nChecks++; if ({mValid, mLast, mData} !== {1'b0, 1'b0, 8'h00}) $display("[TB] FAIL rst_mid_out: got v%b l%b %h expected v0 l0 00", mValid, mLast, mData); else nPass++;
    nChecks++; if (sReady !== 4'b0000) $display("[TB] FAIL rst_mid_idle: got %b expected 0000", sReady); else nPass++;
    sValid = 4'b0101;
    setPort(0, 8'h80, 1'b1);
    step();
    nChecks++; if (sReady !== 4'b0001) $display("[TB] FAIL rst_mid_fresh: got %b expected 0001", sReady); else nPass++;
    step();
    nChecks++; if ({mValid, mData} !== {1'b1, 8'h80}) $display("[TB] FAIL rst_mid_beat: got v%b %h expected v1 80", mValid, mData); else nPass++;
    sValid = '0;
    step();
  endtask

  task automatic test_random();
    int         mPtr;
    int         mGrant;
    int         total;
    int         sent;
    bit         mBusy;
    bit         eValid;
    logic [7:0] eData;
    bit         eLast;
    int         eTid;
    bit         done;
    bit         acc;
    bit         found;
    logic [8:0] beat;
    logic [NP-1:0] expReady;

    doReset();
    mPtr = 0; mGrant = 0; mBusy = 0;
    eValid = 0; eData = '0; eLast = 0; eTid = 0;
    total = 0; sent = 0; done = 0;
    for (int p = 0; p < NP; p++) begin
      pktQ[p].delete();
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          pktQ[p].push_back({(b == len - 1), 8'($urandom)});
          total++;
        end
      end
    end

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (pktQ[p].size() > 0) begin
          sValid[p] = ($urandom_range(0, 3) != 0);
          setPort(p, pktQ[p][0][7:0], pktQ[p][0][8]);
        end else begin
          sValid[p] = 1'b0;
          setPort(p, 8'h00, 1'b0);
        end
      end
      mReady = ($urandom_range(0, 3) != 0);
      #1;

      expReady = '0;
      if (mBusy && (!eValid || mReady)) expReady[mGrant] = 1'b1;
      nChecks++; if (sReady !== expReady) $display("[TB] FAIL rand_ready c%0d: got %b expected %b", cyc, sReady, expReady); else nPass++;
      nChecks++; if (mValid !== eValid) $display("[TB] FAIL rand_valid c%0d: got %b expected %b", cyc, mValid, eValid); else nPass++;
      if (eValid) begin
        nChecks++; if ({mLast, mData} !== {eLast, eData}) $display("[TB] FAIL rand_beat c%0d: got l%b %h expected l%b %h", cyc, mLast, mData, eLast, eData); else nPass++;
`ifdef AXIS_ARB_TID_EN
        nChecks++; if (mTid !== IW'(eTid)) $display("[TB] FAIL rand_tid c%0d: got %0d expected %0d", cyc, mTid, eTid); else nPass++;
`else
`endif
      end

      acc  = expReady[mGrant] && sValid[mGrant];
      beat = '0;
      if (acc) begin
        beat   = pktQ[mGrant].pop_front();
        eValid = 1'b1;
        eData  = beat[7:0];
        eLast  = beat[8];
        eTid   = mGrant;
        sent++;
      end else if (mReady) begin
        eValid = 1'b0;
      end
      if (!mBusy) begin
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          if (!found && sValid[(mPtr + k) % NP]) begin
            found  = 1'b1;
            mGrant = (mPtr + k) % NP;
          end
        end
        mBusy = found;
      end else if (acc && beat[8]) begin
        mBusy = 1'b0;
        mPtr  = (mGrant + 1) % NP;
      end

      step();
      done = (sent == total) && !eValid && !mBusy;
    end
    sValid = '0;
    nChecks++; if (!done) $display("[TB] FAIL rand_complete: delivered %0d of %0d beats within budget", sent, total); else nPass++;
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_mid_packet();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
